// File: rtl/bin2bcd_pkg.sv
// ---------------------------------------------------------------------------
// bin2bcd_pkg
// Shared types and constants for the sequential binary-to-BCD converter.
//   state_t      : converter FSM states (IDLE / SHIFT / DONE)
//   ADD3_THRESH  : a digit at or above this value is corrected before a shift
//   ADD3_CORR    : correction added to such a digit
// ---------------------------------------------------------------------------
package bin2bcd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [3:0] ADD3_THRESH = 4'd5;
   localparam logic [3:0] ADD3_CORR   = 4'd3;

endpackage : bin2bcd_pkg

// File: rtl/bcd_digit_adj.sv
// ---------------------------------------------------------------------------
// bcd_digit_adj
// One combinational add-3 correction cell for a single BCD digit.
// A digit >= 5 would become >= 10 after the next doubling, so adding 3
// first makes the carry land in the next digit.
//   digit_in  [3:0] : accumulator digit before correction
//   digit_out [3:0] : corrected digit
// ---------------------------------------------------------------------------
module bcd_digit_adj
   import bin2bcd_pkg::*;
(
   input  logic [3:0] digit_in,
   output logic [3:0] digit_out
);

   always_comb begin
      if (digit_in >= ADD3_THRESH) digit_out = digit_in + ADD3_CORR;
      else                         digit_out = digit_in;
   end

endmodule : bcd_digit_adj

// File: rtl/bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq
// Sequential shift-and-add3 binary-to-BCD converter, one bit per cycle.
//
// Parameters
//   WIDTH  : binary operand width (4..20)
//   DIGITS : number of BCD digits in the result
//
// Ports
//   clk        in   sole clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operand present on in_bin
//   in_ready   out  converter is idle and accepts an operand
//   in_bin     in   binary operand [WIDTH-1:0]
//   out_valid  out  result present on out_bcd
//   out_ready  in   consumer takes the result
//   out_bcd    out  BCD result [4*DIGITS-1:0], digit 0 in bits [3:0]
//   busy       out  conversion in progress (SHIFT state)
//   out_blank  out  [DIGITS-1:0] leading-zero blanking flags, only when
//                   BIN2BCD_SEQ_BLANK_EN is defined
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. The producer holds valid (and data) until that edge; ready may
// depend on state only. Input is taken only in IDLE; anything offered in
// SHIFT or DONE is dropped, not queued. The result stays on out_bcd after
// it is taken until the next operand is accepted.
//
// Timing: the accepting edge loads the operand; WIDTH edges perform the
// shifts; one more edge moves SHIFT->DONE, so out_valid rises WIDTH+1 edges
// after acceptance.
// ---------------------------------------------------------------------------
module bin2bcd_seq
   import bin2bcd_pkg::*;
#(
   parameter int WIDTH  = 10,
   parameter int DIGITS = 4
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WIDTH-1:0]      in_bin,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*DIGITS-1:0]   out_bcd,
   output logic                  busy
`ifdef BIN2BCD_SEQ_BLANK_EN
   ,
   output logic [DIGITS-1:0]     out_blank
`endif
);

   localparam int BW = 4 * DIGITS;
   localparam int CW = $clog2(WIDTH + 1);

   state_t            state_q;
   state_t            state_d;
   logic [CW-1:0]     count_q;
   logic [WIDTH-1:0]  op_q;
   logic [BW-1:0]     acc_q;
   logic [BW-1:0]     acc_adj;
   logic [BW+WIDTH-1:0] shifted;
   logic              accept;
   logic              shift_en;

   assign accept   = (state_q == IDLE) && in_valid;
   assign shift_en = (state_q == SHIFT) && (count_q != '0);

   // Single time-shared bank of correction cells over the accumulator.
   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (
         .digit_in  (acc_q[4*g +: 4]),
         .digit_out (acc_adj[4*g +: 4])
      );
   end

   // Corrected accumulator and remaining operand bits move left as one word.
   assign shifted = {acc_adj, op_q} << 1;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid)         state_d = SHIFT;
         SHIFT:   if (count_q == '0)    state_d = DONE;
         DONE:    if (out_ready)        state_d = IDLE;
         default:                       state_d = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == DONE);
      busy      = (state_q == SHIFT);
   end

   // ---------------- datapath ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
         op_q    <= '0;
         acc_q   <= '0;
      end else if (accept) begin
         count_q <= CW'(WIDTH);
         op_q    <= in_bin;
         acc_q   <= '0;
      end else if (shift_en) begin
         count_q <= count_q - CW'(1);
         op_q    <= shifted[WIDTH-1:0];
         acc_q   <= shifted[BW+WIDTH-1:WIDTH];
      end
   end

   assign out_bcd = acc_q;

`ifdef BIN2BCD_SEQ_BLANK_EN
   // Bit i set when digit i and every digit above it are zero. Digit 0 is
   // never blanked so a zero result still shows one digit. Gated by
   // out_valid so the flags read 0 outside DONE, including in reset.
   always_comb begin
      logic zero_above;
      zero_above = 1'b1;
      out_blank  = '0;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         zero_above   = zero_above && (acc_q[4*i +: 4] == 4'd0);
         out_blank[i] = zero_above && out_valid;
      end
   end
`endif

endmodule : bin2bcd_seq

// File: tb/tb_bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// tb_bin2bcd_seq
// Self-checking bench for bin2bcd_seq (WIDTH=10, DIGITS=4). Expected results
// come from a decimal-arithmetic model; inputs change and outputs are
// sampled on the falling edge.
// Optional feature covered when BIN2BCD_SEQ_BLANK_EN is defined.
// ---------------------------------------------------------------------------
module tb_bin2bcd_seq;

   localparam int WIDTH  = 10;
   localparam int DIGITS = 4;
   localparam int BW     = 4 * DIGITS;

   logic              clk;
   logic              rst_n;
   logic              in_valid;
   logic              in_ready;
   logic [WIDTH-1:0]  in_bin;
   logic              out_valid;
   logic              out_ready;
   logic [BW-1:0]     out_bcd;
   logic              busy;
`ifdef BIN2BCD_SEQ_BLANK_EN
   logic [DIGITS-1:0] out_blank;
`endif

   int checks = 0;
   int errors = 0;
   logic [BW-1:0] exp_q[$];

   bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_bin    (in_bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_bcd   (out_bcd),
      .busy      (busy)
`ifdef BIN2BCD_SEQ_BLANK_EN
      ,
      .out_blank (out_blank)
`endif
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- watchdog ----------------
   initial begin
      #5_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [BW-1:0] model_bcd(input int v);
      logic [BW-1:0] r;
      int rem;
      r   = '0;
      rem = v;
      for (int d = 0; d < DIGITS; d++) begin
         r[4*d +: 4] = 4'(rem % 10);
         rem         = rem / 10;
      end
      return r;
   endfunction

   function automatic int bcd_value(input logic [BW-1:0] b);
      int sum, scale;
      sum   = 0;
      scale = 1;
      for (int d = 0; d < DIGITS; d++) begin
         sum   = sum + int'(b[4*d +: 4]) * scale;
         scale = scale * 10;
      end
      return sum;
   endfunction

   function automatic int max_digit(input logic [BW-1:0] b);
      int m;
      m = 0;
      for (int d = 0; d < DIGITS; d++)
         if (int'(b[4*d +: 4]) > m) m = int'(b[4*d +: 4]);
      return m;
   endfunction

`ifdef BIN2BCD_SEQ_BLANK_EN
   function automatic logic [DIGITS-1:0] model_blank(input int v);
      logic [DIGITS-1:0] r;
      int scale;
      r     = '0;
      scale = 10;
      for (int i = 1; i < DIGITS; i++) begin
         r[i]  = (v < scale);
         scale = scale * 10;
      end
      return r;
   endfunction
`endif

   // ---------------- driver: one full conversion ----------------
   // Called at a falling edge with the DUT idle. Offers v, checks latency,
   // holds out_ready low for 'stall' cycles (optionally offering 7 during
   // the stall), then completes the handshake. Returns at the falling edge
   // right after the handshake edge.
   task automatic convert(input int v, input int stall, input bit inject);
      logic [BW-1:0] exp;
      int lat;
      exp_q.push_back(model_bcd(v));
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_bin    = WIDTH'(v);
      check("in_ready_idle", in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      check("busy_after_accept", busy, 1);
      check("in_ready_shift", in_ready, 0);
      lat = 0;
      for (int k = 1; k <= WIDTH + 5; k++) begin
         @(negedge clk);
         lat = k;
         if (out_valid) break;
         check("busy_shift", busy, 1);
      end
      check("latency", lat, WIDTH + 1);
      exp = exp_q.pop_front();
      if (out_valid) begin
         check("out_bcd", out_bcd, exp);
         check("digit_range", max_digit(out_bcd) <= 9, 1);
         check("decimal_value", bcd_value(out_bcd), v);
         check("busy_done", busy, 0);
`ifdef BIN2BCD_SEQ_BLANK_EN
         check("out_blank", out_blank, model_blank(v));
`endif
      end
      for (int s = 0; s < stall; s++) begin
         if (inject) begin
            in_valid = 1'b1;
            in_bin   = WIDTH'(7);
         end
         @(negedge clk);
         check("stall_valid", out_valid, 1);
         check("stall_bcd", out_bcd, exp);
         check("stall_in_ready", in_ready, 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("post_valid", out_valid, 0);
      check("post_hold_bcd", out_bcd, exp);
      check("post_in_ready", in_ready, 1);
      if (inject) begin
         @(negedge clk);
         check("inject_ignored", busy, 0);
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int vcount;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_bin    = '0;
      out_ready = 1'b0;

      // Reset state
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_out_bcd", out_bcd, 0);
`ifdef BIN2BCD_SEQ_BLANK_EN
      check("rst_out_blank", out_blank, 0);
`endif
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      check("rst_in_ready", in_ready, 1);

      // Full-scale value with immediate take: one cycle of out_valid
      convert(1023, 0, 0);
      // Zero result
      convert(0, 0, 0);
      // Stalled consumer with an ignored operand offered meanwhile
      convert(59, 5, 1);
      // Back-to-back: second accepted the cycle after the handshake
      convert(999, 0, 0);
      convert(1, 0, 0);

      // Reset mid-SHIFT aborts the conversion
      in_valid = 1'b1;
      in_bin   = WIDTH'(500);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      check("abort_busy_before", busy, 1);
      rst_n = 1'b0;
      #1;
      check("abort_out_valid", out_valid, 0);
      check("abort_out_bcd", out_bcd, 0);
      check("abort_in_ready", in_ready, 1);
      check("abort_busy", busy, 0);
      repeat (2) @(negedge clk);
      rst_n  = 1'b1;
      vcount = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (out_valid || busy) vcount++;
      end
      check("abort_no_result", vcount, 0);

      // Every operand value with random consumer stalls
      for (int v = 0; v < (1 << WIDTH); v++)
         convert(v, $urandom_range(0, 3), 1'b0);

      // A few random operands with random stalls and ignored offers
      for (int n = 0; n < 20; n++)
         convert($urandom_range(0, (1 << WIDTH) - 1), $urandom_range(0, 4), 1'($urandom_range(0, 1)));

      check("exp_q_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_bin2bcd_seq

// File: doc/bin2bcd_seq.md
BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 10, meaning binary input width (range 4..20).
REQ-002 SHALL have parameter DIGITS, default 4, meaning BCD output digit count; DIGITS*4 SHALL hold 2^WIDTH-1 in decimal.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  binary operand present.
REQ-006 SHALL have port in_ready  output  1  block can accept an operand.
REQ-007 SHALL have port in_bin  input  WIDTH  binary operand.
REQ-008 SHALL have port out_valid  output  1  BCD result present.
REQ-009 SHALL have port out_ready  input  1  consumer takes the result.
REQ-010 SHALL have port out_bcd  output  4*DIGITS  BCD result, digit 0 (LSD) in bits [3:0].
REQ-011 SHALL have port busy  output  1  conversion in progress.

Function
REQ-012 SHALL implement a sequential shift-and-add3 conversion using one time-shared bank of DIGITS per-digit correction cells.
REQ-013 SHALL use an FSM with states IDLE, SHIFT and DONE.
REQ-014 In IDLE: in_ready=1; on in_valid=1, latch in_bin, clear the BCD accumulator, load count=WIDTH, go to SHIFT.
REQ-015 In SHIFT, each cycle: add 3 to every accumulator digit >=5, then shift {accumulator, operand} left by one; decrement count.
REQ-016 SHALL transition SHIFT->DONE on the cycle count reaches 0, after exactly WIDTH SHIFT cycles.
REQ-017 out_valid SHALL rise exactly WIDTH+1 clock edges after the accepting edge, and out_bcd SHALL be stable while out_valid=1.
REQ-018 In DONE: hold out_valid=1 until out_ready=1; on that edge go to IDLE with out_valid=0.
REQ-019 in_ready SHALL be 0 in SHIFT and DONE; operands presented there SHALL be ignored and not queued.
REQ-020 busy SHALL be 1 exactly in SHIFT.
REQ-021 out_bcd SHALL hold the last result after the DONE->IDLE transition, until the next acceptance clears it.
REQ-022 Each digit of the result SHALL be in 0..9, and sum(digit_i*10^i) SHALL equal in_bin.

Reset
REQ-023 While rst_n=0: state=IDLE, out_valid=0, busy=0, out_bcd=0, count=0, and in_ready=1 after release.
REQ-024 Reset asserted in SHIFT or DONE SHALL abort the conversion with no result delivered.
REQ-025 The first acceptance SHALL occur on the first rising clk edge with rst_n=1 and in_valid=1.

Configuration
REQ-026 Macro BIN2BCD_SEQ_BLANK_EN, when defined, SHALL add output out_blank [DIGITS-1:0], bit i=1 when digit i and all higher digits are zero; out_blank[0] SHALL always be 0; out_blank SHALL be valid with out_valid and reset to 0.
REQ-027 Without BIN2BCD_SEQ_BLANK_EN, the out_blank port and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-028 SHALL place the FSM state enum (IDLE/SHIFT/DONE), the add3 threshold constant 5 and the correction constant 3 in package bin2bcd_pkg.
REQ-029 SHALL implement the per-digit correction as sub-module bcd_digit_adj (4-bit in/out, combinational), instantiated DIGITS times.

Verification
REQ-030 Reset mid-SHIFT: rst_n low 3 cycles after accepting 500 -> out_valid=0, out_bcd=0, in_ready=1; no result after release.
REQ-031 in_bin=1023 accepted, out_ready=1 -> out_valid high on edge 11 after accept, out_bcd=0x1023, held one cycle.
REQ-032 in_bin=0 -> out_bcd=0x0000; with BIN2BCD_SEQ_BLANK_EN out_blank=4'b1110.
REQ-033 in_bin=59, out_ready=0 for 5 cycles -> out_valid and out_bcd=0x0059 held stable; in_valid with 7 during that time ignored (in_ready=0).
REQ-034 Back-to-back 999 then 1: second operand accepted the cycle after out_ready handshake -> results 0x0999 then 0x0001.
REQ-035 Exhaustive 0..1023 with random out_ready stalls -> every result digit <=9 and decimal value equal to input.
